// File: rtl/dqn_seq_ctrl.sv
// dqn_seq_ctrl: phase sequencer for one DQN training iteration.
// Orders the weight commit (W1..W3), the forward pass (Z1..Z3) and backprop (BP),
// then signals completion via done/episode_end. It is the only source of the
// ctrl/step codes decoded by the weight banks and the layer datapaths.
// Optional feature macro: DQN_SEQ_TIMEOUT_EN (BP watchdog that raises err).
module dqn_seq_ctrl #(
    parameter int unsigned N_STEPS   = 15,
    parameter int unsigned LAYER_CYC = 4,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       delta_vld,
    output logic [3:0] ctrl,
    output logic [3:0] step,
    output logic       busy,
    output logic       done,
    output logic       episode_end,
    output logic       err
);

    localparam int unsigned CTRL_W  = 4;
    localparam int unsigned STEP_W  = 4;
    localparam int unsigned PHASE_W = 8;

    typedef enum logic [CTRL_W-1:0] {
        S_IDLE = 4'd0,
        S_W1   = 4'd1,
        S_W2   = 4'd2,
        S_W3   = 4'd3,
        S_Z1   = 4'd4,
        S_Z2   = 4'd5,
        S_Z3   = 4'd6,
        S_BP   = 4'd7,
        S_FIN  = 4'd8
    } state_t;

    localparam logic [PHASE_W-1:0] PHASE_LOAD = PHASE_W'(LAYER_CYC - 1);
    localparam logic [STEP_W-1:0]  STEP_MAX   = STEP_W'(N_STEPS);

    state_t              state_q;
    logic [STEP_W-1:0]   step_q;
    logic [PHASE_W-1:0]  phase_cnt_q;
    logic                busy_q;
    logic                done_q;
    logic                eoe_q;
    logic                err_q;
    logic [STEP_W-1:0]   step_next;

`ifdef DQN_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wd_cnt_q;
`else
    localparam int unsigned UNUSED_TIMEOUT = TIMEOUT;
`endif

    // Step to use for the next iteration: wrap to 1 after the last step of an episode
    assign step_next = ((step_q == '0) || (step_q == STEP_MAX)) ? STEP_W'(1)
                                                              : step_q + STEP_W'(1);

    // Sequencer state, phase counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            phase_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            eoe_q       <= 1'b0;
            err_q       <= 1'b0;
`ifdef DQN_SEQ_TIMEOUT_EN
            wd_cnt_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            eoe_q  <= 1'b0;
            if (abort) begin
                state_q <= S_IDLE;
                step_q  <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            step_q <= step_next;
                            err_q  <= 1'b0;
                            busy_q <= 1'b1;
                            if (step_next == STEP_W'(1)) begin
                                // first step of an episode has no deltas to commit
                                state_q     <= S_Z1;
                                phase_cnt_q <= PHASE_LOAD;
                            end else begin
                                state_q <= S_W1;
                            end
                        end
                    end
                    S_W1: state_q <= S_W2;
                    S_W2: state_q <= S_W3;
                    S_W3: begin
                        state_q     <= S_Z1;
                        phase_cnt_q <= PHASE_LOAD;
                    end
                    S_Z1, S_Z2, S_Z3: begin
                        if (phase_cnt_q == '0) begin
                            phase_cnt_q <= PHASE_LOAD;
                            if (state_q == S_Z1) begin
                                state_q <= S_Z2;
                            end else if (state_q == S_Z2) begin
                                state_q <= S_Z3;
                            end else begin
                                state_q <= S_BP;
`ifdef DQN_SEQ_TIMEOUT_EN
                                wd_cnt_q <= '0;
`endif
                            end
                        end else begin
                            phase_cnt_q <= phase_cnt_q - PHASE_W'(1);
                        end
                    end
                    S_BP: begin
                        if (delta_vld) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                            eoe_q   <= (step_q == STEP_MAX);
`ifdef DQN_SEQ_TIMEOUT_EN
                        end else if (wd_cnt_q == WD_LAST) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            wd_cnt_q <= wd_cnt_q + WD_W'(1);
`endif
                        end
                    end
                    S_FIN: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ctrl        = state_q;
    assign step        = step_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign episode_end = eoe_q;
    assign err         = err_q;

endmodule

// File: tb/tb_dqn_seq_ctrl.sv
// Directed bench for dqn_seq_ctrl (N_STEPS=15, LAYER_CYC=4, TIMEOUT=64).
module tb_dqn_seq_ctrl;

    localparam int unsigned NS = 15;
    localparam int unsigned LC = 4;
    localparam int unsigned TO = 64;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       delta_vld;
    logic [3:0] ctrl;
    logic [3:0] step;
    logic       busy;
    logic       done;
    logic       episode_end;
    logic       err;

    int vectors = 0;
    int errs    = 0;

    dqn_seq_ctrl #(.N_STEPS(NS), .LAYER_CYC(LC), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .delta_vld   (delta_vld),
        .ctrl        (ctrl),
        .step        (step),
        .busy        (busy),
        .done        (done),
        .episode_end (episode_end),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [3:0] exp_step);
        chk({tag, "_ctrl"}, 32'(ctrl), 32'(0));
        chk({tag, "_step"}, 32'(step), 32'(exp_step));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_eoe"},  32'(episode_end), 32'(0));
    endtask

    // One full iteration; expected ctrl trace built from the phase ordering
    task automatic run_iter(input logic [3:0] es, input int bp, input bit eoe, input bit start_at_fin);
        logic [3:0] seq[$];
        int         done_at;
        int         exp_lat;
        seq = {};
        done_at = -1;
        if (es != 4'd1) begin
            seq.push_back(4'd1); seq.push_back(4'd2); seq.push_back(4'd3);
        end
        for (int k = 0; k < int'(LC); k++) seq.push_back(4'd4);
        for (int k = 0; k < int'(LC); k++) seq.push_back(4'd5);
        for (int k = 0; k < int'(LC); k++) seq.push_back(4'd6);
        for (int k = 0; k < bp; k++) seq.push_back(4'd7);
        seq.push_back(4'd8);
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < seq.size(); i++) begin
            chk("ctrl", 32'(ctrl), 32'(seq[i]));
            chk("step", 32'(step), 32'(es));
            chk("busy", 32'(busy), 32'(1));
            chk("done", 32'(done), 32'(seq[i] == 4'd8));
            chk("eoe",  32'(episode_end), 32'(eoe && (seq[i] == 4'd8)));
            chk("err",  32'(err), 32'(0));
            if (done === 1'b1 && done_at < 0) done_at = i + 1;
            delta_vld = (seq[i] == 4'd7) && (i == seq.size() - 2);
            if (seq[i] == 4'd8) start = start_at_fin;
            tick;
            delta_vld = 1'b0;
        end
        start = 1'b0;
        exp_lat = (es == 4'd1) ? (3 * int'(LC) + bp + 1) : (3 + 3 * int'(LC) + bp + 1);
        chk("latency", 32'(done_at), 32'(exp_lat));
        chk_idle("post", es);
        if (start_at_fin) begin
            tick;
            chk_idle("fin_start_ignored", es);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        delta_vld = 1'b0;
        #2;
        chk_idle("reset", 4'd0);
        chk("reset_err", 32'(err), 32'(0));
        tick; tick;
        rst_n = 1'b1;
        tick;
        chk_idle("after_reset", 4'd0);

        // Step 1: no W phases, done 15 cycles after start
        run_iter(4'd1, 2, 1'b0, 1'b0);
        chk("lat_step1_hand", 32'(3 * LC + 2 + 1), 32'(15));
        // Step 2: W1..W3 first, done 18 cycles after start; start during FIN ignored
        run_iter(4'd2, 2, 1'b0, 1'b1);
        // Steps 3..15; episode_end only on the 15th
        for (int s = 3; s <= 15; s++) begin
            run_iter(4'(s), (s % 3) + 1, (s == 15), 1'b0);
        end
        // Wrap to step 1, then 2..4
        run_iter(4'd1, 1, 1'b0, 1'b0);
        for (int s = 2; s <= 4; s++) run_iter(4'(s), 2, 1'b0, 1'b0);

        // Step 5: stray delta_vld in Z1, start in Z2 ignored, abort in Z2
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("s5_ctrl_w1", 32'(ctrl), 32'(1));
        chk("s5_step", 32'(step), 32'(5));
        for (int c = 1; c < 5; c++) tick;
        chk("s5_ctrl_z1", 32'(ctrl), 32'(4));
        delta_vld = 1'b1;
        tick;
        delta_vld = 1'b0;
        for (int c = 6; c < 9; c++) tick;
        chk("s5_ctrl_z2", 32'(ctrl), 32'(5));
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("s5_start_ign_ctrl", 32'(ctrl), 32'(5));
        chk("s5_start_ign_step", 32'(step), 32'(5));
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk_idle("abort", 4'd0);
        tick;
        chk_idle("abort_nodone", 4'd0);

        // abort with start in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        chk_idle("abort_start", 4'd0);

        // Async reset mid-BP
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("rst_step", 32'(step), 32'(1));
        for (int c = 1; c < 13; c++) tick;
        chk("rst_in_bp", 32'(ctrl), 32'(7));
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst", 4'd0);
        chk("async_rst_err", 32'(err), 32'(0));
        #1;
        rst_n = 1'b1;
        tick;
        chk_idle("rst_release", 4'd0);

`ifdef DQN_SEQ_TIMEOUT_EN
        // BP watchdog: 64 BP cycles without delta_vld
        begin
            int seen_done;
            seen_done = 0;
            start = 1'b1;
            tick;
            start = 1'b0;
            for (int c = 1; c < 13; c++) tick;
            chk("to_bp", 32'(ctrl), 32'(7));
            for (int c = 13; c < 13 + int'(TO) - 1; c++) begin
                if (done === 1'b1) seen_done++;
                tick;
            end
            chk("to_still_bp", 32'(ctrl), 32'(7));
            tick;
            chk_idle("to_exit", 4'd1);
            chk("to_err", 32'(err), 32'(1));
            chk("to_nodone", 32'(seen_done), 32'(0));
            start = 1'b1;
            tick;
            start = 1'b0;
            chk("to_err_clr", 32'(err), 32'(0));
            chk("to_restart_ctrl", 32'(ctrl), 32'(1));
            chk("to_restart_step", 32'(step), 32'(2));
            abort = 1'b1;
            tick;
            abort = 1'b0;
        end
`else
        chk("err_tied", 32'(err), 32'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/dqn_seq_ctrl.md
# dqn_seq_ctrl

Sequencer for one DQN training iteration. It drives the 4-bit `ctrl` phase code and the 4-bit `step` counter that the weight banks (w1/w2/w3) and the layer datapaths decode. It orders weight commit, forward pass (z1→z2→z3) and backprop, and handshakes with the top-level controller through start/done. It sits between the accelerator top and every layer/weight block, and is their only source of `ctrl` and `step`.

## Interface
- `N_STEPS`, default 15: steps per episode (1..15); `step` never exceeds it.
- `LAYER_CYC`, default 4: cycles each forward phase (Z1/Z2/Z3) is held (1..255).
- `TIMEOUT`, default 64: backprop watchdog limit in cycles; used only with DQN_SEQ_TIMEOUT_EN.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin one iteration; sampled only in IDLE.
- `abort`  in  1  synchronous abort to IDLE; clears `step` to 0.
- `delta_vld`  in  1  backprop unit reports all deltaw ready; sampled only in BP.
- `ctrl`  out  4  phase code (see Operation).
- `step`  out  4  current step; 0 = reset/no episode.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at end of each iteration.
- `episode_end`  out  1  one-cycle pulse, coincident with `done`, when `step == N_STEPS`.
- `err`  out  1  sticky watchdog error; cleared by `start` or reset.

## Operation
- FSM states and their `ctrl` codes: IDLE=0, W1=1, W2=2, W3=3, Z1=4, Z2=5, Z3=6, BP=7, FIN=8. Codes 9–15 are never driven.
- IDLE, `start`=1: `step` ← 1 if `step`==0 or `step`==N_STEPS, otherwise `step`+1. Next state is Z1 when the new step is 1 (no deltas exist yet); otherwise W1.
- W1, W2, W3: one cycle each, in that order. W3 is the single cycle in which weight3 adds its deltas.
- Z1, Z2, Z3: each held for exactly LAYER_CYC cycles, tracked by an 8-bit phase counter that reloads on every phase entry.
- BP: held until `delta_vld`=1, then FIN. A `delta_vld` pulse seen outside BP is ignored.
- FIN: one cycle; `done`=1 (plus `episode_end`=1 when `step`==N_STEPS); then IDLE. `step` holds its value in IDLE.
- `abort` has priority over every transition. It forces IDLE with `step`=0 on the next edge and no `done` pulse. `abort` together with `start` in IDLE: abort wins.
- `start` outside IDLE is ignored; it is not queued.

## Timing
- All outputs are registered. The `ctrl`/`step` change is visible on the clock edge that enters the state.
- Reset values: `ctrl`=0, `step`=0, `busy`=0, `done`=0, `episode_end`=0, `err`=0, phase counter=0.
- Reset asserted mid-iteration returns to IDLE immediately (asynchronously), with all outputs at their reset values.
- Iteration latency, start edge to `done` edge, for step>1: 3 + 3·LAYER_CYC + B + 1 cycles, where B ≥ 1 is the number of BP cycles. For step 1 it is 3 cycles less.
- `step` changes only on the IDLE→W1/Z1 transition, on `abort` and on reset. It is stable for the whole iteration.
- `start` sampled high in the same cycle FIN returns to IDLE is ignored. The earliest accepted restart is the cycle after IDLE is entered.

## Configuration
- `DQN_SEQ_TIMEOUT_EN` defined: a watchdog counts cycles in BP. If TIMEOUT cycles elapse without `delta_vld`, the FSM goes to IDLE with no `done` pulse, `err` ← 1 and `step` unchanged.
- `DQN_SEQ_TIMEOUT_EN` not defined: BP waits indefinitely, `err` is tied to 0 and the TIMEOUT parameter is unused.

## Test plan
- Reset, then `start` with `delta_vld` at BP cycle 2, LAYER_CYC=4 -> `step`=1; `ctrl` sequence 4×4, 5×4, 6×4, 7×2, 8; `done` 15 cycles after start.
- Second `start` -> `step`=2; `ctrl` 1,2,3 each one cycle, then as above; `done` 18 cycles after start.
- Run 15 iterations with N_STEPS=15 -> `episode_end` only with the 15th `done`; the next `start` gives `step`=1 and no W phases.
- `abort` during Z2 of step 5 -> next cycle `ctrl`=0, `step`=0, `busy`=0, no `done`; `start` in Z2 is ignored.
- `rst_n` low mid-BP -> all outputs 0 immediately, without waiting for a clock edge.
- With DQN_SEQ_TIMEOUT_EN and TIMEOUT=64, `delta_vld` never asserted -> after 64 BP cycles `err`=1, `ctrl`=0, no `done`; the next `start` clears `err`.
